iob_timer_sched: RTL
====================

Name: iob_timer_sched

Overview:
- Alarm scheduler for the 64-bit free-running timer counter.
- Holds NCH compare channels, each one-shot or periodic.
- Time-shares a single 64-bit compare/add datapath across the channels round-robin.
- Raises per-channel pending flags and one OR-ed interrupt.
- Sits beside the timer core: takes its 64-bit value and is configured from the CPU-side register file.

Parameters:
- NCH, 4, number of alarm channels (2..16).
- DATA_W, 32, CPU word width; timer value is 2*DATA_W.
- CH_W, $clog2(NCH), channel index width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- timer_value  in  2*DATA_W  current timer count
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  CH_W  target channel
- cfg_addr  in  2  0=CMP_LO, 1=CMP_HI, 2=PERIOD_LO, 3=CTRL
- cfg_wdata  in  DATA_W  write data; CTRL bit0=ARM, bit1=PERIODIC
- ack_we  in  1  pending-clear strobe
- ack_ch  in  CH_W  channel to clear
- pending  out  NCH  per-channel fired flags
- armed  out  NCH  per-channel armed status
- irq  out  1  OR of pending

Behaviour:
- Reset: pending=0, armed=0, irq=0; all cmp/period/periodic cleared; ptr=0; FSM=SCAN.
- Per-channel storage:
  - cmp: 64 bits.
  - period: DATA_W bits, zero-extended to 64 for the add.
  - periodic: 1 bit.
  - armed: 1 bit.
- Config writes take effect on the next clock edge. CTRL write loads armed=bit0 and periodic=bit1. Writing CMP_LO or CMP_HI does not change armed.
- Hit test (wrap-safe): diff = timer_value - cmp, mod 2^64. Hit when diff[63]==0 and armed.
- FSM:
  - SCAN: evaluate channel ptr. On hit, latch ptr and go to UPDATE. Otherwise ptr = (ptr+1) mod NCH and stay in SCAN.
  - UPDATE: set pending[ch].
    - If periodic and period!=0: cmp += period, mod 2^64; armed stays 1.
    - Else: armed=0.
    - Then ptr=(ptr+1) mod NCH and return to SCAN.
- Latency: a channel whose time has been reached sets pending at most 2*NCH cycles later. irq is registered, so it follows pending by 1 cycle.
- Periodic with period=0 behaves as one-shot, so it cannot fire repeatedly.
- Periodic catch-up: if the timer has passed several periods, each scan visit fires again until cmp overtakes the timer. pending is sticky; the extra firings are not counted without the optional feature.
- Simultaneous events:
  - cfg write to the channel currently in UPDATE: the cfg write wins for the register it targets. pending is still set.
  - ack and set of the same channel in the same cycle: set wins, pending stays 1.
  - ack of a channel that is not pending: no effect.
- cfg_ch or ack_ch >= NCH: ignored.
- rst mid-UPDATE: full reset, and no pending is set.
- timer_value is sampled combinationally each SCAN cycle. It is not required to be monotonic; a backward jump (soft reset of the timer) simply delays hits.

Optional Feature:
- Macro: TIMER_SCHED_OVR_EN.
- With the macro defined:
  - Adds output overrun[NCH], reset 0.
  - overrun[ch] is set when UPDATE occurs on a channel whose pending was already 1.
  - ack clears pending and overrun together.
  - irq = |pending | |overrun.
- Without the macro: no overrun port or logic; a repeated fire is silently absorbed.

Decomposition:
- Shared header iob_timer_sched.vh holds:
  - cfg address defines: TSCHED_CMP_LO=0, TSCHED_CMP_HI=1, TSCHED_PERIOD=2, TSCHED_CTRL=3.
  - CTRL bit positions: TSCHED_ARM_BIT=0, TSCHED_PER_BIT=1.
  - FSM state encodings: SCAN=0, UPDATE=1.
- One sub-module, timer_sched_cmp: purely combinational wrap-safe compare (hit) and 64-bit reload adder (next_cmp). It is instantiated once and shared by all channels.

Test Plan:
- One-shot hit: ch0 cmp=100, ARM=1, timer ramps from 0. Required:
  - pending[0] rises by timer=100+2*NCH;
  - armed[0] drops to 0;
  - irq is high the cycle after pending[0].
- Periodic reload: ch1 cmp=50, period=20, PERIODIC|ARM. Required:
  - fires near 50, 70 and 90, with ack after each;
  - cmp reads 110 after the third firing.
- Wrap-around: ch2 cmp=0x0000_0000_0000_0010, timer starts at 0xFFFF_FFFF_FFFF_FFF0. Required:
  - no hit before the timer wraps;
  - hit at timer>=0x10.
- Collision: in the same cycle, ack ch0 and UPDATE sets ch0 -> pending[0] stays 1. Separately, cfg CTRL=0 to ch3 during its UPDATE -> armed[3]=0 and pending[3]=1.
- Period zero: PERIODIC|ARM with period=0 -> single fire, then armed=0.
- Overrun (TIMER_SCHED_OVR_EN): periodic period=5 and no ack across two firings -> overrun set; a single ack clears both pending and overrun. Assert reset mid-UPDATE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/iob_timer_sched_pkg.sv
// Shared constants and types for the alarm scheduler: config addresses,
// CTRL bit positions and the scan/update state encoding.
package iob_timer_sched_pkg;

  localparam logic [1:0] TSCHED_CMP_LO = 2'd0;
  localparam logic [1:0] TSCHED_CMP_HI = 2'd1;
  localparam logic [1:0] TSCHED_PERIOD = 2'd2;
  localparam logic [1:0] TSCHED_CTRL   = 2'd3;

  localparam int TSCHED_ARM_BIT = 0;
  localparam int TSCHED_PER_BIT = 1;

  typedef enum logic {
    SCAN   = 1'b0,
    UPDATE = 1'b1
  } sched_state_t;

endpackage

// File: rtl/iob_timer_sched_if.sv
// Bus bundle between the CPU-side register file / timer core and the scheduler.
// Optional overrun flags are present when TIMER_SCHED_OVR_EN is defined.
interface iob_timer_sched_if #(
  parameter int NCH    = 4,
  parameter int DATA_W = 32
);
  import iob_timer_sched_pkg::*;

  localparam int CH_W = $clog2(NCH);

  // cfg_we and ack_we are single-cycle strobes with no back-pressure: the
  // scheduler accepts every strobe on the clock edge where it is high.
  logic [2*DATA_W-1:0] timer_value;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_addr;
  logic [DATA_W-1:0]   cfg_wdata;
  logic                ack_we;
  logic [CH_W-1:0]     ack_ch;
  logic [NCH-1:0]      pending;
  logic [NCH-1:0]      armed;
  logic                irq;
`ifdef TIMER_SCHED_OVR_EN
  logic [NCH-1:0]      overrun;
`endif
  sched_state_t        state;

  modport master (
    output timer_value, cfg_we, cfg_ch, cfg_addr, cfg_wdata, ack_we, ack_ch,
`ifdef TIMER_SCHED_OVR_EN
    input  overrun,
`endif
    input  pending, armed, irq, state
  );

  modport slave (
    input  timer_value, cfg_we, cfg_ch, cfg_addr, cfg_wdata, ack_we, ack_ch,
`ifdef TIMER_SCHED_OVR_EN
    output overrun,
`endif
    output pending, armed, irq, state
  );

endinterface

// File: rtl/iob_timer_sched_cmp.sv
// Shared combinational datapath: wrap-safe "time reached" test and the
// periodic reload adder, time-multiplexed across all channels.
module timer_sched_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] timer_value,
  input  logic [2*DATA_W-1:0] cmp,
  input  logic [DATA_W-1:0]   period,
  input  logic                armed,
  output logic                hit,
  output logic [2*DATA_W-1:0] next_cmp
);

  logic [2*DATA_W-1:0] diff;

  // A non-negative modular difference means the deadline is at or behind us.
  assign diff     = timer_value - cmp;
  assign hit      = armed && !diff[2*DATA_W-1];
  assign next_cmp = cmp + {{DATA_W{1'b0}}, period};

endmodule

// File: rtl/iob_timer_sched.sv
// Round-robin alarm scheduler over NCH compare channels of the 64-bit timer.
// Define TIMER_SCHED_OVR_EN to add per-channel overrun flags.
module iob_timer_sched
  import iob_timer_sched_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DATA_W = 32
) (
  input logic            clk,
  input logic            rst,
  iob_timer_sched_if.slave bus
);

  localparam int CH_W = $clog2(NCH);
  localparam int TW   = 2 * DATA_W;

  logic [TW-1:0]     cmp_q    [NCH];
  logic [DATA_W-1:0] period_q [NCH];
  logic [NCH-1:0]    periodic_q;
  logic [NCH-1:0]    armed_q;
  logic [NCH-1:0]    pending_q;
  logic              irq_q;
`ifdef TIMER_SCHED_OVR_EN
  logic [NCH-1:0]    overrun_q;
`endif

  sched_state_t    state_q, state_next;
  logic [CH_W-1:0] ptr_q, ptr_next, ptr_inc;

  logic          hit;
  logic [TW-1:0] next_cmp;
  logic          reload;
  logic          cfg_valid;
  logic          ack_valid;

  timer_sched_cmp #(.DATA_W(DATA_W)) u_cmp (
    .timer_value (bus.timer_value),
    .cmp         (cmp_q[ptr_q]),
    .period      (period_q[ptr_q]),
    .armed       (armed_q[ptr_q]),
    .hit         (hit),
    .next_cmp    (next_cmp)
  );

  assign ptr_inc   = (ptr_q == CH_W'(NCH - 1)) ? '0 : ptr_q + 1'b1;
  assign reload    = periodic_q[ptr_q] && (period_q[ptr_q] != '0);
  assign cfg_valid = bus.cfg_we && (int'(bus.cfg_ch) < NCH);
  assign ack_valid = bus.ack_we && (int'(bus.ack_ch) < NCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
      ptr_q   <= '0;
    end else begin
      state_q <= state_next;
      ptr_q   <= ptr_next;
    end
  end

  // ptr holds on a hit so UPDATE works on the channel that was just tested.
  always_comb begin
    state_next = state_q;
    ptr_next   = ptr_q;
    case (state_q)
      SCAN: begin
        if (hit) state_next = UPDATE;
        else     ptr_next   = ptr_inc;
      end
      UPDATE: begin
        state_next = SCAN;
        ptr_next   = ptr_inc;
      end
      default: begin
        state_next = SCAN;
        ptr_next   = '0;
      end
    endcase
  end

  // Ordering matters: ack before set (set wins), cfg last (cfg wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cmp_q[i]    <= '0;
        period_q[i] <= '0;
      end
      periodic_q <= '0;
      armed_q    <= '0;
      pending_q  <= '0;
      irq_q      <= 1'b0;
`ifdef TIMER_SCHED_OVR_EN
      overrun_q  <= '0;
`endif
    end else begin
`ifdef TIMER_SCHED_OVR_EN
      irq_q <= (|pending_q) | (|overrun_q);
`else
      irq_q <= |pending_q;
`endif

      if (ack_valid) begin
        pending_q[bus.ack_ch] <= 1'b0;
`ifdef TIMER_SCHED_OVR_EN
        overrun_q[bus.ack_ch] <= 1'b0;
`endif
      end

      if (state_q == UPDATE) begin
        pending_q[ptr_q] <= 1'b1;
`ifdef TIMER_SCHED_OVR_EN
        if (pending_q[ptr_q]) overrun_q[ptr_q] <= 1'b1;
`endif
        if (reload) cmp_q[ptr_q]   <= next_cmp;
        else        armed_q[ptr_q] <= 1'b0;
      end

      if (cfg_valid) begin
        case (bus.cfg_addr)
          TSCHED_CMP_LO: cmp_q[bus.cfg_ch][DATA_W-1:0]  <= bus.cfg_wdata;
          TSCHED_CMP_HI: cmp_q[bus.cfg_ch][TW-1:DATA_W] <= bus.cfg_wdata;
          TSCHED_PERIOD: period_q[bus.cfg_ch]           <= bus.cfg_wdata;
          TSCHED_CTRL: begin
            armed_q[bus.cfg_ch]    <= bus.cfg_wdata[TSCHED_ARM_BIT];
            periodic_q[bus.cfg_ch] <= bus.cfg_wdata[TSCHED_PER_BIT];
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.pending = pending_q;
  assign bus.armed   = armed_q;
  assign bus.irq     = irq_q;
  assign bus.state   = state_q;
`ifdef TIMER_SCHED_OVR_EN
  assign bus.overrun = overrun_q;
`endif

endmodule
